// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control codes, FSM states and
// the shift-class helper used by both the FSM and the datapath.
package alu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // One bit per control code; set for SLL (4), SRL (5) and SRA (8).
    localparam logic [15:0] SHIFT_MASK = 16'h0130;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return SHIFT_MASK[code];
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result handshake bundle between the operand muxes, the execute unit
// and writeback. The slave side is the execute unit itself.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
) ();
    import alu_pkg::*;

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid never waits on ready, and once
    // raised it holds with stable payload until the transfer.
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    alu_state_t      state;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, state
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, state
    );

endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle logic/arithmetic/compare core. Shift codes and unknown codes
// fall through to ADD, matching the control decoder default.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic lt_signed;
    logic lt_unsigned;

    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        y = a + b;
        case (ctrl)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: one-cycle logic/arithmetic, bit-serial shifts,
// registered result and zero flag behind an output handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);

    alu_state_t       state_q;
    alu_state_t       state_d;
    logic [3:0]       ctrl_q;
    logic [XLEN-1:0]  work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;
    logic             zero_q;

    logic [XLEN-1:0]    core_y;
    logic [XLEN-1:0]    shift_step;
    logic [SHAMT_W-1:0] shamt_in;
    logic               accept;
    logic               last_shift;

    alu_comb_core #(
        .XLEN (XLEN)
    ) u_core (
        .ctrl (bus.alu_ctrl),
        .a    (bus.op_a),
        .b    (bus.op_b),
        .y    (core_y)
    );

    assign shamt_in   = bus.op_b[SHAMT_W-1:0];
    assign accept     = (state_q == ST_IDLE) && bus.in_valid;
    assign last_shift = (cnt_q == SHAMT_W'(1));

    // Handshake outputs come from state alone, never from in_valid/out_ready.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.state     = state_q;

    always_comb begin
        shift_step = {work_q[XLEN-2:0], 1'b0};
        case (ctrl_q)
            ALU_SRL: shift_step = {1'b0, work_q[XLEN-1:1]};
            ALU_SRA: shift_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: shift_step = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift(bus.alu_ctrl) && (shamt_in != '0)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= ALU_ADD;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ctrl_q <= bus.alu_ctrl;
                if (is_shift(bus.alu_ctrl)) begin
                    // A zero shift amount skips the SHIFT state entirely.
                    if (shamt_in == '0) begin
                        result_q <= bus.op_a;
                        zero_q   <= (bus.op_a == '0);
                    end else begin
                        work_q <= bus.op_a;
                        cnt_q  <= shamt_in;
                    end
                end else begin
                    result_q <= core_y;
                    zero_q   <= (core_y == '0);
                end
            end else if (state_q == ST_SHIFT) begin
                work_q <= shift_step;
                cnt_q  <= cnt_q - SHAMT_W'(1);
                if (last_shift) begin
                    result_q <= shift_step;
                    zero_q   <= (shift_step == '0);
                end
            end
        end
    end

endmodule
